writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have parameter: DATA_W, 32, register and datapath width in bits.
REQ-002 SHALL have parameter: NREGS, 32, number of architectural registers (address width = log2(NREGS) = 5).
REQ-003 SHALL have port: clock  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: result  input  DATA_W  ALU result from the MEM/WB pipeline register.
REQ-006 SHALL have port: readData  input  DATA_W  load data from the MEM/WB pipeline register.
REQ-007 SHALL have port: rd  input  5  destination register index from MEM/WB.
REQ-008 SHALL have port: memToReg  input  1  1 = write readData, 0 = write result.
REQ-009 SHALL have port: regWrite  input  1  write enable from MEM/WB.
REQ-010 SHALL have ports: rs_addr, rt_addr  input  5  decode-stage read addresses.
REQ-011 SHALL have ports: rs_data, rt_data  output  DATA_W  decode-stage read data.
REQ-012 SHALL have port: wb_data  output  DATA_W  selected writeback value, exported for EX-stage forwarding.
REQ-013 SHALL have port: retired  output  32  count of committed register writes.

Function
REQ-014 SHALL drive wb_data combinationally: readData when memToReg = 1, else result.
REQ-015 SHALL commit a write when regWrite = 1, rd != 0, and reset = 0: reg[rd] <= wb_data at posedge clock.
REQ-016 SHALL hardwire register 0: writes to rd = 0 are discarded, and reads of address 0 return 0.
REQ-017 SHALL provide combinational reads with zero-cycle latency: rs_data = reg[rs_addr], and likewise rt_data.
REQ-018 SHALL bypass write-before-read: when a write commits this cycle and rd == rs_addr != 0, rs_data = wb_data (same rule for rt_data).
REQ-019 SHALL apply the bypass independently to both read ports; rs_addr == rt_addr == rd SHALL return wb_data on both ports.
REQ-020 SHALL treat an all-zero input bundle (pipeline bubble) as a no-op: no write, retired unchanged.
REQ-021 SHALL increment retired by 1 on every committed write (REQ-015 conditions) and hold it otherwise.
REQ-022 SHALL wrap retired from 0xFFFFFFFF to 0 without flag or saturation.
REQ-023 SHALL NOT count writes to rd = 0, even when regWrite = 1.
REQ-024 SHALL ignore memToReg and the data inputs when regWrite = 0.

Reset
REQ-025 SHALL, on posedge clock with reset = 1, clear all NREGS registers to 0 and set retired to 0.
REQ-026 SHALL give reset priority over a simultaneous write: neither the write nor the counter increment takes effect.
REQ-027 SHALL force rs_data and rt_data to 0 and suppress the bypass while reset = 1.
REQ-028 SHALL perform no register writes in the cycle reset asserts mid-stream; normal operation SHALL resume on the first posedge after deassertion.

Structure
REQ-029 SHALL take DATA_W, NREGS, REG_ZERO (= 5'd0), and the reset value (0) from a shared processor package, which the pipeline registers also use.
REQ-030 SHALL place the storage array and its single write port in one sub-module, regfile_array; wb_data selection, bypass, and the counter SHALL live in the top level.
REQ-031 SHALL fit within 120-400 lines of RTL and SHALL have no combinational path from the read outputs back to the write inputs.

Verification
REQ-032 Reset, then read all 32 addresses -> every read returns 0, and retired = 0.
REQ-033 regWrite=1, rd=5, memToReg=0, result=0x1234 -> next cycle reg5 = 0x1234 and retired = 1; with memToReg=1 and readData=0xBEEF, reg5 = 0xBEEF and retired = 2.
REQ-034 Same cycle: write rd=7 with data 0xA5A5A5A5, rs_addr=7, rt_addr=7 -> rs_data = rt_data = 0xA5A5A5A5 before the edge.
REQ-035 regWrite=1, rd=0, result=0xFFFFFFFF -> reg0 reads 0, and retired is unchanged.
REQ-036 Preload retired = 0xFFFFFFFF via 2^32-1 writes (or a force), then commit one write -> retired = 0.
REQ-037 reset=1 concurrent with write rd=3 of 0x55 -> reg3 = 0, retired = 0, and rs_data = 0 during reset.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Shared processor constants: datapath width, register count, x0 index and
// the value registers take on reset. Pipeline registers import this too.
package writeback_regfile_pkg;
  localparam int P_DATA_W = 32;
  localparam int P_NREGS  = 32;
  localparam int P_ADDR_W = 5;

  localparam logic [P_ADDR_W-1:0] REG_ZERO = 5'd0;
  // Every bit of a register is cleared to this on reset.
  localparam logic RST_BIT = 1'b0;
endpackage

// File: rtl/regfile_array.sv
// Register storage: NREGS x DATA_W array with one write port and two raw
// asynchronous read ports. Gating of x0 and bypass live in the parent.
module regfile_array
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = P_DATA_W,
  parameter int NREGS  = P_NREGS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                we,
  input  logic [P_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [P_ADDR_W-1:0] raddr0,
  input  logic [P_ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1
);

  logic [DATA_W-1:0] mem [NREGS];

  // Clear every entry on reset; otherwise commit the single write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= {DATA_W{RST_BIT}};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/writeback_regfile.sv
// WB stage + register file: selects the writeback value, commits it, serves
// two decode read ports with same-cycle bypass, and counts retired writes.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = P_DATA_W,
  parameter int NREGS  = P_NREGS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   result,
  input  logic [DATA_W-1:0]   readData,
  input  logic [P_ADDR_W-1:0] rd,
  input  logic                memToReg,
  input  logic                regWrite,
  input  logic [P_ADDR_W-1:0] rs_addr,
  input  logic [P_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  output logic [DATA_W-1:0]   wb_data,
  output logic [31:0]         retired
);

  logic              commit;
  logic [DATA_W-1:0] arr_rs, arr_rt;
  logic [31:0]       retired_q;

  assign wb_data = memToReg ? readData : result;
  // Reset outranks any write; x0 writes are dropped and never counted.
  assign commit  = regWrite && (rd != REG_ZERO) && !reset;

  regfile_array #(.DATA_W(DATA_W), .NREGS(NREGS)) u_array (
    .clock  (clock),
    .reset  (reset),
    .we     (commit),
    .waddr  (rd),
    .wdata  (wb_data),
    .raddr0 (rs_addr),
    .raddr1 (rt_addr),
    .rdata0 (arr_rs),
    .rdata1 (arr_rt)
  );

  // Read ports: zero in reset or for x0, bypass a same-cycle commit, else storage.
  always_comb begin
    rs_data = arr_rs;
    rt_data = arr_rt;
    if (reset || rs_addr == REG_ZERO) rs_data = '0;
    else if (commit && rd == rs_addr) rs_data = wb_data;
    if (reset || rt_addr == REG_ZERO) rt_data = '0;
    else if (commit && rd == rt_addr) rt_data = wb_data;
  end

  // Retired-write counter; wraps naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset)       retired_q <= '0;
    else if (commit) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset state, writes from both
// sources, bypass, x0 handling, bubbles, reset priority and counter wrap.
module tb_writeback_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] result, readData;
  logic [4:0]  rd, rs_addr, rt_addr;
  logic        memToReg, regWrite;
  logic [31:0] rs_data, rt_data, wb_data, retired;

  int n_chk = 0;
  int n_err = 0;

  writeback_regfile dut (
    .clock    (clock),
    .reset    (reset),
    .result   (result),
    .readData (readData),
    .rd       (rd),
    .memToReg (memToReg),
    .regWrite (regWrite),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wb_data  (wb_data),
    .retired  (retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle outputs away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bubble();
    regWrite = 1'b0; memToReg = 1'b0; rd = 5'd0; result = '0; readData = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic m2r, input logic [31:0] res, input logic [31:0] ld);
    regWrite = 1'b1; rd = a; memToReg = m2r; result = res; readData = ld;
  endtask

  // Read a register through the rs port with no write in flight.
  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bubble();
    rs_addr = a;
    #1;
    check(tag, rs_data, exp);
  endtask

  initial begin
    reset = 1'b1; rs_addr = '0; rt_addr = '0;
    bubble();
    tick(); tick();
    reset = 1'b0;
    #1;

    // Everything reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      #1;
      check($sformatf("rst_rs%0d", i), rs_data, 32'h0);
      check($sformatf("rst_rt%0d", 31 - i), rt_data, 32'h0);
    end
    check("rst_retired", retired, 32'd0);

    // ALU result writeback.
    wr(5'd5, 1'b0, 32'h1234, 32'hDEAD_0000);
    #1 check("wb_sel_result", wb_data, 32'h1234);
    tick();
    rd_chk("reg5_alu", 5'd5, 32'h1234);
    check("retired_1", retired, 32'd1);

    // Load data writeback.
    wr(5'd5, 1'b1, 32'h1111, 32'hBEEF);
    #1 check("wb_sel_load", wb_data, 32'hBEEF);
    tick();
    rd_chk("reg5_load", 5'd5, 32'hBEEF);
    check("retired_2", retired, 32'd2);

    // Same-cycle bypass on both ports, then one port bypassed, other not.
    wr(5'd7, 1'b0, 32'hA5A5_A5A5, 32'h0);
    rs_addr = 5'd7; rt_addr = 5'd7;
    #1;
    check("byp_rs", rs_data, 32'hA5A5_A5A5);
    check("byp_rt", rt_data, 32'hA5A5_A5A5);
    rt_addr = 5'd5;
    #1;
    check("byp_rt_other", rt_data, 32'hBEEF);
    tick();
    rd_chk("reg7", 5'd7, 32'hA5A5_A5A5);
    check("retired_3", retired, 32'd3);

    // Writes to x0 are dropped, not bypassed, not counted.
    wr(5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    rs_addr = 5'd0;
    #1 check("x0_nobyp", rs_data, 32'h0);
    tick();
    rd_chk("x0_read", 5'd0, 32'h0);
    check("x0_retired", retired, 32'd3);

    // Bubble and regWrite=0 leave state alone; rs=rd but nothing commits.
    bubble();
    tick();
    check("bubble_retired", retired, 32'd3);
    regWrite = 1'b0; rd = 5'd5; memToReg = 1'b1; readData = 32'h9999; result = 32'h7777;
    rs_addr = 5'd5;
    #1;
    check("nowr_wb", wb_data, 32'h9999);
    check("nowr_nobyp", rs_data, 32'hBEEF);
    tick();
    rd_chk("nowr_reg5", 5'd5, 32'hBEEF);
    check("nowr_retired", retired, 32'd3);

    // Reset wins over a simultaneous write and gates the read ports.
    reset = 1'b1;
    wr(5'd3, 1'b0, 32'h55, 32'h0);
    rs_addr = 5'd5; rt_addr = 5'd3;
    #1;
    check("rst_rs_gate", rs_data, 32'h0);
    check("rst_rt_nobyp", rt_data, 32'h0);
    tick();
    reset = 1'b0;
    rd_chk("rst_reg3", 5'd3, 32'h0);
    rd_chk("rst_reg5", 5'd5, 32'h0);
    rd_chk("rst_reg7", 5'd7, 32'h0);
    check("rst_retired0", retired, 32'd0);

    // First edge after deassertion commits normally.
    wr(5'd3, 1'b0, 32'h55, 32'h0);
    tick();
    rd_chk("resume_reg3", 5'd3, 32'h55);
    check("resume_retired", retired, 32'd1);

    // Counter wrap from all-ones.
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1 check("wrap_pre", retired, 32'hFFFF_FFFF);
    wr(5'd9, 1'b0, 32'hCAFE, 32'h0);
    tick();
    bubble();
    #1;
    check("wrap_retired", retired, 32'd0);
    rd_chk("wrap_reg9", 5'd9, 32'hCAFE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
